// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

  // Loader frame-parsing states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HDR_ADDR  = 3'd1,
    HDR_ENTRY = 3'd2,
    HDR_CNT   = 3'd3,
    DATA      = 3'd4,
    CSUM      = 3'd5,
    START     = 3'd6
  } state_t;

  localparam int unsigned HDR_ADDR_BYTES  = 4;
  localparam int unsigned HDR_ENTRY_BYTES = 4;
  localparam int unsigned HDR_CNT_BYTES   = 2;
  localparam int unsigned WORD_BYTES      = 4;

  // True when a 2-bit byte counter sits on the last byte of a field of nbytes
  function automatic logic field_last(input logic [1:0] cnt, input int unsigned nbytes);
    return (cnt == 2'(nbytes - 32'd1));
  endfunction

endpackage

// File: rtl/imem_loader_word_asm.sv
// Little-endian byte-to-word assembler: collects four bytes, strobes word_done
// in the cycle the fourth byte is accepted and presents {b3,b2,b1,b0}.
module imem_word_asm
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_done
);

  logic [1:0]  r_idx;
  logic [23:0] r_shift;

  // Completed word uses the current byte as the most-significant byte
  assign o_word      = {i_byte, r_shift};
  assign o_word_done = i_en && (r_idx == 2'(WORD_BYTES - 32'd1));

  // Shift bytes in from the top so byte 0 ends up in the low lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= 2'd0;
      r_shift <= 24'h000000;
    end else if (i_clr) begin
      r_idx   <= 2'd0;
      r_shift <= 24'h000000;
    end else if (i_en) begin
      r_idx   <= r_idx + 2'd1;
      r_shift <= {i_byte, r_shift[23:8]};
    end else begin
      r_idx   <= r_idx;
      r_shift <= r_shift;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader: parses a framed byte stream, writes payload words into the
// instruction memory and, after a good checksum, pulses INT with the entry PC.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              abort,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W-1:0] entry_point,
  output logic              INT,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]        r_byte_cnt;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [ADDR_W-1:0] r_load_addr;
  logic [ADDR_W-1:0] r_entry;
  logic [7:0]        r_xor;

  logic              r_rx_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [ADDR_W-1:0] r_entry_point;
  logic              r_int;
  logic              r_busy;
  logic              r_err;

  logic              w_acc;
  logic              w_take;
  logic              w_csum_ok;
  logic              w_last_word;
  logic              w_asm_en;
  logic              w_asm_clr;
  logic              w_word_done;
  logic [31:0]       w_word;
  logic [ADDR_W-1:0] w_addr_shift;
  logic [ADDR_W-1:0] w_entry_shift;
  logic [CNT_W-1:0]  w_count_new;
  logic [ADDR_W-1:0] w_word_off;

  assign w_acc         = rx_valid && r_rx_ready;
  assign w_take        = w_acc && !abort;
  assign w_csum_ok     = (rx_data == r_xor);
  assign w_last_word   = ((r_word_cnt + CNT_W'(1'b1)) == r_count);
  assign w_addr_shift  = {rx_data, r_load_addr[ADDR_W-1:8]};
  assign w_entry_shift = {rx_data, r_entry[ADDR_W-1:8]};
  assign w_count_new   = {rx_data, r_count[CNT_W-1:8]};
  assign w_word_off    = ADDR_W'({r_word_cnt, 2'b00});
  assign w_asm_en      = w_take && (r_state == DATA);
  assign w_asm_clr     = abort || (r_state != DATA);

  imem_word_asm u_word_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_asm_clr),
    .i_en        (w_asm_en),
    .i_byte      (rx_data),
    .o_word      (w_word),
    .o_word_done (w_word_done)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; abort wins over any byte offered in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc) w_state_nxt = HDR_ADDR;
          else       w_state_nxt = IDLE;
        end
        HDR_ADDR: begin
          if (w_acc && field_last(r_byte_cnt, HDR_ADDR_BYTES)) w_state_nxt = HDR_ENTRY;
          else                                                 w_state_nxt = HDR_ADDR;
        end
        HDR_ENTRY: begin
          if (w_acc && field_last(r_byte_cnt, HDR_ENTRY_BYTES)) w_state_nxt = HDR_CNT;
          else                                                  w_state_nxt = HDR_ENTRY;
        end
        HDR_CNT: begin
          if (w_acc && field_last(r_byte_cnt, HDR_CNT_BYTES)) begin
            if (w_count_new == {CNT_W{1'b0}}) w_state_nxt = CSUM;
            else                              w_state_nxt = DATA;
          end else begin
            w_state_nxt = HDR_CNT;
          end
        end
        DATA: begin
          if (w_word_done && w_last_word) w_state_nxt = CSUM;
          else                            w_state_nxt = DATA;
        end
        CSUM: begin
          if (w_acc) begin
            if (w_csum_ok) w_state_nxt = START;
            else           w_state_nxt = IDLE;
          end else begin
            w_state_nxt = CSUM;
          end
        end
        START:   w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Header fields, byte/word counters, running XOR and the sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt  <= 2'd0;
      r_count     <= {CNT_W{1'b0}};
      r_word_cnt  <= {CNT_W{1'b0}};
      r_load_addr <= {ADDR_W{1'b0}};
      r_entry     <= {ADDR_W{1'b0}};
      r_xor       <= 8'h00;
      r_err       <= 1'b0;
    end else if (abort) begin
      r_byte_cnt <= 2'd0;
      r_word_cnt <= {CNT_W{1'b0}};
      r_xor      <= 8'h00;
    end else if (w_acc) begin
      case (r_state)
        IDLE: begin
          r_load_addr <= w_addr_shift;
          r_xor       <= rx_data;
          r_byte_cnt  <= 2'd1;
          r_word_cnt  <= {CNT_W{1'b0}};
          r_err       <= 1'b0;
        end
        HDR_ADDR: begin
          r_xor <= r_xor ^ rx_data;
          if (field_last(r_byte_cnt, HDR_ADDR_BYTES)) begin
            r_load_addr <= w_addr_shift & ALIGN_MASK;
            r_byte_cnt  <= 2'd0;
          end else begin
            r_load_addr <= w_addr_shift;
            r_byte_cnt  <= r_byte_cnt + 2'd1;
          end
        end
        HDR_ENTRY: begin
          r_xor <= r_xor ^ rx_data;
          if (field_last(r_byte_cnt, HDR_ENTRY_BYTES)) begin
            r_entry    <= w_entry_shift & ALIGN_MASK;
            r_byte_cnt <= 2'd0;
          end else begin
            r_entry    <= w_entry_shift;
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        HDR_CNT: begin
          r_xor   <= r_xor ^ rx_data;
          r_count <= w_count_new;
          if (field_last(r_byte_cnt, HDR_CNT_BYTES)) begin
            r_byte_cnt <= 2'd0;
            r_word_cnt <= {CNT_W{1'b0}};
          end else begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        DATA: begin
          r_xor <= r_xor ^ rx_data;
          if (w_word_done) begin
            r_word_cnt <= w_last_word ? {CNT_W{1'b0}} : (r_word_cnt + CNT_W'(1'b1));
          end else begin
            r_word_cnt <= r_word_cnt;
          end
        end
        CSUM: begin
          r_xor <= 8'h00;
          if (!w_csum_ok) r_err <= 1'b1;
          else            r_err <= r_err;
        end
        default: begin
          r_xor <= r_xor;
        end
      endcase
    end else begin
      r_xor <= r_xor;
    end
  end

  // Registered outputs: handshake/status follow the next state, writes follow word_done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_ready    <= 1'b1;
      r_busy        <= 1'b0;
      r_int         <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= {ADDR_W{1'b0}};
      r_mem_wdata   <= 32'h0000_0000;
      r_entry_point <= {ADDR_W{1'b0}};
    end else begin
      r_rx_ready <= (w_state_nxt != START);
      r_busy     <= (w_state_nxt != IDLE);
      r_int      <= (w_state_nxt == START);
      r_mem_we   <= w_word_done;
      if (w_word_done) begin
        r_mem_addr  <= r_load_addr + w_word_off;
        r_mem_wdata <= w_word;
      end else begin
        r_mem_addr  <= r_mem_addr;
        r_mem_wdata <= r_mem_wdata;
      end
      if (w_state_nxt == START) r_entry_point <= r_entry;
      else                      r_entry_point <= r_entry_point;
    end
  end

  assign rx_ready    = r_rx_ready;
  assign busy        = r_busy;
  assign INT         = r_int;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign entry_point = r_entry_point;
  assign err         = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the driver builds frames from a reference
// model and queues expected writes / start pulses; a monitor checks them.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        abort = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] entry_point;
  logic        INT;
  logic        busy;
  logic        err;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_waddr_q[$];
  logic [31:0] exp_wdata_q[$];
  logic [31:0] exp_entry_q[$];
  logic [31:0] data_w [0:7];
  logic [31:0] mon_a;
  logic [31:0] mon_d;

  always #5 clk = ~clk;

  imem_loader #(.CNT_W(16), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .abort(abort), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .entry_point(entry_point), .INT(INT), .busy(busy), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe and start pulse must match the scoreboard head
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        if (exp_waddr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write addr=%h data=%h required=none", mem_addr, mem_wdata);
        end else begin
          mon_a = exp_waddr_q.pop_front();
          mon_d = exp_wdata_q.pop_front();
          check("wr_addr", mem_addr, mon_a);
          check("wr_data", mem_wdata, mon_d);
        end
      end
      if (INT) begin
        if (exp_entry_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_int entry=%h required=none", entry_point);
        end else begin
          mon_a = exp_entry_q.pop_front();
          check("int_entry", entry_point, mon_a);
        end
      end
    end
  end

  // Offer one byte (called just after a negedge) until it is transferred;
  // returns just after the following negedge.
  task automatic send_byte(input logic [7:0] b, input int pct);
    int  guard;
    bit  acc;
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 2000) begin
      rx_data  = b;
      rx_valid = ($urandom_range(0, 99) < pct);
      acc      = rx_valid && rx_ready;
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    rx_valid = 1'b0;
    if (!acc) begin
      checks++; failures++;
      $display("FAIL send_timeout byte=%h accepted=0 required=1", b);
    end
  endtask

  // Reference model: build the frame, queue expectations, drive the bytes.
  // stop_at >= 0 sends only that many bytes (partial frame).
  task automatic send_frame(input logic [31:0] load, input logic [31:0] entry, input int n,
                            input bit bad, input int pct, input int stop_at);
    logic [7:0]  bq[$];
    logic [7:0]  x;
    logic [15:0] n16;
    int          total;
    int          w;
    bit          wend;
    bq  = {};
    n16 = 16'(n);
    for (int i = 0; i < 4; i++) bq.push_back(load[8*i +: 8]);
    for (int i = 0; i < 4; i++) bq.push_back(entry[8*i +: 8]);
    bq.push_back(n16[7:0]);
    bq.push_back(n16[15:8]);
    for (int k = 0; k < n; k++)
      for (int j = 0; j < 4; j++) bq.push_back(data_w[k][8*j +: 8]);
    x = 8'h00;
    foreach (bq[i]) x = x ^ bq[i];
    bq.push_back(bad ? (x ^ 8'h01) : x);
    total = (stop_at >= 0) ? stop_at : bq.size();
    for (int i = 0; i < total; i++) begin
      wend = (i >= 10) && (i < 10 + 4*n) && (((i - 10) % 4) == 3);
      w    = (i - 10) / 4;
      if (wend) begin
        exp_waddr_q.push_back((load & 32'hFFFF_FFFC) + 32'(4 * w));
        exp_wdata_q.push_back(data_w[w]);
      end
      if (i == bq.size() - 1 && !bad) exp_entry_q.push_back(entry & 32'hFFFF_FFFC);
      send_byte(bq[i], pct);
      if (i == 0) begin
        check("err_clear", {31'd0, err}, 32'd0);
        check("busy_set", {31'd0, busy}, 32'd1);
      end
      if (wend) check("we_latency", {31'd0, mem_we}, 32'd1);
      if (i == bq.size() - 1) begin
        check("int_latency", {31'd0, INT}, {31'd0, !bad});
        check("err_flag", {31'd0, err}, {31'd0, bad});
        if (!bad) check("start_ready", {31'd0, rx_ready}, 32'd0);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  {31'd0, busy},     32'd0);
    check({tag, "_int"},   {31'd0, INT},      32'd0);
    check({tag, "_we"},    {31'd0, mem_we},   32'd0);
    check({tag, "_ready"}, {31'd0, rx_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired=1 required=0");
    $fatal(1);
  end

  initial begin
    // Reset values
    #12;
    check_idle_outputs("rst");
    check("rst_err",   {31'd0, err}, 32'd0);
    check("rst_addr",  mem_addr,     32'd0);
    check("rst_wdata", mem_wdata,    32'd0);
    check("rst_entry", entry_point,  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reference frame from the program example
    data_w[0] = 32'h0050_0093;
    send_frame(32'h28, 32'h28, 1, 1'b0, 100, -1);
    @(negedge clk);
    @(negedge clk);
    check("entry_held", entry_point, 32'h28);

    // Bad checksum, then a good frame clears err
    send_frame(32'h28, 32'h28, 1, 1'b1, 100, -1);
    @(negedge clk);
    check("bad_idle", {31'd0, busy}, 32'd0);
    send_frame(32'h28, 32'h28, 1, 1'b0, 100, -1);

    // Empty payload
    send_frame(32'h0, 32'h40, 0, 1'b0, 100, -1);

    // Address wrap and misaligned load address
    data_w[0] = 32'hDEAD_BEEF; data_w[1] = 32'h1234_5678;
    send_frame(32'hFFFF_FFFC, 32'h100, 2, 1'b0, 100, -1);
    data_w[0] = 32'hA5A5_0F0F;
    send_frame(32'h2B, 32'h2F, 1, 1'b0, 100, -1);

    // 3-word frame with 50% valid
    data_w[0] = 32'h1111_2222; data_w[1] = 32'h3333_4444; data_w[2] = 32'h5555_6666;
    send_frame(32'h200, 32'h204, 3, 1'b0, 50, -1);

    // Random frames, back to back
    for (int f = 0; f < 8; f++) begin
      int n;
      n = $urandom_range(0, 4);
      for (int k = 0; k < 8; k++) data_w[k] = $urandom;
      send_frame($urandom, $urandom, n, ($urandom_range(0, 3) == 0), $urandom_range(30, 100), -1);
    end

    // Reset in the middle of DATA, then a full frame
    data_w[0] = 32'hCAFE_0001; data_w[1] = 32'hCAFE_0002; data_w[2] = 32'hCAFE_0003;
    send_frame(32'h400, 32'h404, 3, 1'b0, 100, 15);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("mrst");
    check("mrst_err",   {31'd0, err}, 32'd0);
    check("mrst_addr",  mem_addr,     32'd0);
    check("mrst_wdata", mem_wdata,    32'd0);
    check("mrst_entry", entry_point,  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(32'h500, 32'h504, 3, 1'b0, 100, -1);

    // Abort in HDR_CNT together with an offered byte, then a full frame
    send_frame(32'h600, 32'h604, 2, 1'b0, 100, 9);
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    abort    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    abort    = 1'b0;
    check_idle_outputs("abort");
    send_frame(32'h700, 32'h708, 2, 1'b0, 100, -1);

    repeat (5) @(negedge clk);
    check("wq_empty", 32'(exp_waddr_q.size()), 32'd0);
    check("iq_empty", 32'(exp_entry_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader. It is the writing end of the instruction/data memory that the single-cycle RISC-V core fetches from.
- It receives a framed program image over a valid/ready byte interface and assembles little-endian 32-bit words. It writes them into memory through a word-write port.
- After a frame passes its checksum, it pulses the core's INT input with the frame's entry point, so the core starts at that address.

Parameters:
- CNT_W, 16, width of the word-count field and of the internal word counter.
- ADDR_W, 32, width of the memory address, the entry point and the frame address fields.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  incoming frame byte.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_ready  out  1  loader accepts a byte; a transfer occurs when rx_valid and rx_ready are both 1 at the edge.
- abort  in  1  synchronous clear to IDLE; no INT is raised.
- mem_we  out  1  one-cycle word-write strobe.
- mem_addr  out  ADDR_W  byte address of the word being written; always word-aligned.
- mem_wdata  out  32  word being written.
- entry_point  out  ADDR_W  start PC for the core; valid while INT = 1 and held afterwards.
- INT  out  1  one-cycle start pulse to the core.
- busy  out  1  a frame is in progress (state is not IDLE).
- err  out  1  sticky checksum-error flag; cleared by the first byte of the next frame or by reset.

Behaviour:
- Frame layout, all fields little-endian:
  - LOAD_ADDR: 4 bytes.
  - ENTRY: 4 bytes.
  - COUNT: 2 bytes (N).
  - Payload: N×4 bytes.
  - CSUM: 1 byte, equal to the XOR of every preceding byte of the frame.
- Address alignment: bits [1:0] of LOAD_ADDR and ENTRY are forced to 0.
- Reset: state = IDLE; rx_ready = 1. mem_we, INT, busy and err are 0. mem_addr, mem_wdata and entry_point are 0. All internal counters and the running XOR are 0.
- State machine:
  - IDLE: on an accepted byte, load it as LOAD_ADDR byte 0, clear err, go to HDR_ADDR.
  - HDR_ADDR: 4 bytes total, then HDR_ENTRY.
  - HDR_ENTRY: 4 bytes, then HDR_CNT.
  - HDR_CNT: 2 bytes. If N = 0, go to CSUM; otherwise go to DATA.
  - DATA: a 2-bit byte index tracks position in the word. When the 4th byte of a word is accepted, the next cycle shows:
    - mem_we = 1;
    - mem_addr = LOAD_ADDR + 4·i, where i is the word index from 0 and the sum is modulo 2^ADDR_W (wraps);
    - mem_wdata = {b3,b2,b1,b0}.
    After word N−1 is accepted, go to CSUM.
  - CSUM: compare the accepted byte with the running XOR.
    - Match: go to START.
    - Mismatch: set err = 1 and go to IDLE; INT is never raised.
  - START: INT = 1 and entry_point = ENTRY for exactly one cycle, then IDLE.
- rx_ready = 0 only in START; it is 1 in every other state. A byte offered in START is held by the sender under the valid/ready rule.
- rx_valid = 0 stalls any state indefinitely; no timeout.
- Latency:
  - Last payload byte accepted at edge k → mem_we high in cycle k+1.
  - Checksum byte accepted at edge k → INT high in cycle k+1.
- Simultaneous events:
  - abort takes priority over an accepted byte in the same cycle. The byte is consumed and discarded.
  - A mem_we pulse already registered still completes.
- rst_n asserted mid-frame: all state is cleared immediately and asynchronously. Already-written words are not undone.
- Running XOR covers LOAD_ADDR through the last payload byte, using the raw bytes before the alignment masking.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, HDR_ADDR, HDR_ENTRY, HDR_CNT, DATA, CSUM, START);
  - the constants HDR_ADDR_BYTES = 4, HDR_ENTRY_BYTES = 4, HDR_CNT_BYTES = 2 and WORD_BYTES = 4.
- One natural sub-module, imem_word_asm: a byte-to-word little-endian shift assembler with a 2-bit index and a word_done strobe.

Test Plan:
- Frame bytes 28 00 00 00 28 00 00 00 01 00 93 00 50 00 C2 → one mem_we with mem_addr = 0x28 and mem_wdata = 0x00500093. One cycle later INT = 1 with entry_point = 0x28; err = 0.
- Same frame with CSUM = C3 → mem_we still pulses once. INT stays 0, err = 1, state returns to IDLE. A following valid frame clears err.
- COUNT = 0 (LOAD_ADDR = 0, ENTRY = 0x40) → no mem_we; INT pulses with entry_point = 0x40 after the correct CSUM.
- LOAD_ADDR = 0xFFFFFFFC, N = 2 → writes go to 0xFFFFFFFC then 0x00000000 (wrap). LOAD_ADDR = 0x2B is written at 0x28.
- rx_valid toggled randomly (50%) across a 3-word frame → same writes and INT as continuous streaming. No byte is accepted while rx_ready = 0 in START.
- rst_n pulled low mid-DATA, and separately abort asserted mid-HDR_CNT → busy = 0 and all outputs 0 (reset) or idle (abort). The next full frame loads correctly.
